fifo_ptr_ctrl: RTL and testbench



---
 rtl/fifo_pkg.sv | 48 ++++
 rtl/gray_sync.sv | 41 ++++
 rtl/fifo_ptr_ctrl.sv | 142 ++++++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and Gray-code helpers for the dual-clock FIFO
//
// Purpose:
//   Common definitions used by every dual-clock FIFO block:
//     fifo_mode_e - which side of the FIFO a pointer controller serves
//     ptr_w()     - pointer width for a given depth (address bits + wrap bit)
//     is_pow2()   - parameter sanity helper
//     bin2gray()  - binary to reflected Gray code
//     gray2bin()  - reflected Gray code to binary
//
//   The conversion helpers work on a fixed-width word.  Callers zero-extend
//   their narrower pointer into it and cast the result back down.  Leading
//   zeros are harmless in both directions, so one function serves every
//   pointer width.
package fifo_pkg;

  typedef enum logic {
    WR = 1'b0,
    RD = 1'b1
  } fifo_mode_e;

  localparam int GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - multi-flop synchroniser for Gray-coded buses
//
// Purpose:
//   Brings a Gray-coded value from a foreign clock domain into the local
//   domain through a STAGES-deep flop chain.  It is only safe for buses
//   that change by at most one bit per source edge, so that any sampled
//   value is either the old or the new code.
//
// Ports:
//   clock      in   1      local-domain clock
//   resetn     in   1      asynchronous active-low reset, clears the chain
//   async_gray in   WIDTH  foreign-domain Gray value
//   sync_gray  out  WIDTH  synchronised value, STAGES edges behind
module gray_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] async_gray,
  output logic [WIDTH-1:0] sync_gray
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= async_gray;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign sync_gray = chain[STAGES-1];

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - per-domain pointer controller for the dual-clock FIFO
//
// Purpose:
//   Owns one side's binary/Gray pointer pair and synchronises the peer's
//   Gray pointer.  MODE=WR gives a write-side controller (flag = full);
//   MODE=RD gives a read-side controller (flag = empty).  Flag, almost flag
//   and level are computed from the next-state pointers and registered, so
//   an accepted inc is reflected at the very next edge.  The peer pointer
//   is always stale by the synchroniser latency, which only errs on the
//   safe side: full is overstated and available data understated.
//
// Ports:
//   clock        in   1   local-domain clock
//   resetn       in   1   asynchronous active-low reset
//   inc          in   1   push (WR) / pop (RD) request
//   remote_gray  in   PW  peer Gray pointer, asynchronous to clock
//   accept       out  1   inc & !flag, combinational
//   ptr_gray     out  PW  registered local Gray pointer, exported to peer
//   addr         out  AW  memory address (low bits of binary pointer)
//   flag         out  1   WR: full, RD: empty (registered)
//   almost_flag  out  1   WR: almost full, RD: almost empty (registered)
//   level        out  PW  WR: entries used, RD: entries available (registered)
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter  int DEPTH       = 8,
  parameter  int SYNC_STAGES = 2,
  parameter  int MODE        = 0,
  parameter  int ALMOST_THR  = 2,
  localparam int AW          = $clog2(DEPTH),
  localparam int PW          = ptr_w(DEPTH)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          inc,
  input  logic [PW-1:0] remote_gray,
  output logic          accept,
  output logic [PW-1:0] ptr_gray,
  output logic [AW-1:0] addr,
  output logic          flag,
  output logic          almost_flag,
  output logic [PW-1:0] level
);

  localparam bit            IS_RD   = (MODE == int'(RD));
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] THR_P   = PW'(ALMOST_THR);

  // Parameter sanity, caught at elaboration.
  if (!is_pow2(DEPTH) || (DEPTH < 4)) begin : g_bad_depth
    $error("fifo_ptr_ctrl: DEPTH must be a power of two and >= 4");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("fifo_ptr_ctrl: SYNC_STAGES must be >= 2");
  end
  if ((ALMOST_THR <= 0) || (ALMOST_THR >= DEPTH)) begin : g_bad_thr
    $error("fifo_ptr_ctrl: ALMOST_THR must satisfy 0 < ALMOST_THR < DEPTH");
  end
  if ((MODE != int'(WR)) && (MODE != int'(RD))) begin : g_bad_mode
    $error("fifo_ptr_ctrl: MODE must be 0 (WR) or 1 (RD)");
  end

  logic [PW-1:0] bin;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rsync;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_pat;
  logic [PW-1:0] level_next;
  logic          flag_next;
  logic          almost_next;

  // ---------------------------------------------------------------------
  // Peer pointer synchronisation
  // ---------------------------------------------------------------------
  gray_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock      (clock),
    .resetn     (resetn),
    .async_gray (remote_gray),
    .sync_gray  (rsync)
  );

  assign rbin = PW'(gray2bin(GRAY_MAX_W'(rsync)));

  // ---------------------------------------------------------------------
  // Next-state pointer
  // ---------------------------------------------------------------------
  // A request against a set flag is silently dropped.
  assign accept    = inc & ~flag;
  assign bin_next  = bin + {{(PW-1){1'b0}}, accept};
  assign gray_next = PW'(bin2gray(GRAY_MAX_W'(bin_next)));

  // ---------------------------------------------------------------------
  // Flag / level from next-state pointer against the synchronised peer.
  // A local inc and a newly visible peer move land in the same compare,
  // so there is no ordering between them.
  // ---------------------------------------------------------------------
  // Full in Gray terms: one lap ahead means the two MSBs are inverted and
  // the rest are equal.
  assign full_pat = {~rsync[PW-1:PW-2], rsync[PW-3:0]};

  always_comb begin
    level_next  = '0;
    flag_next   = 1'b0;
    almost_next = 1'b0;
    if (IS_RD) begin
      level_next  = rbin - bin_next;
      flag_next   = (gray_next == rsync);
      almost_next = (level_next <= THR_P);
    end else begin
      level_next  = bin_next - rbin;
      flag_next   = (gray_next == full_pat);
      almost_next = (level_next >= (DEPTH_P - THR_P));
    end
  end

  // ---------------------------------------------------------------------
  // State registers.  Out of reset the write side is empty (not full) and
  // the read side has nothing available (empty and almost empty).
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bin         <= '0;
      ptr_gray    <= '0;
      flag        <= IS_RD;
      almost_flag <= IS_RD;
      level       <= '0;
    end else begin
      bin         <= bin_next;
      ptr_gray    <= gray_next;
      flag        <= flag_next;
      almost_flag <= almost_next;
      level       <= level_next;
    end
  end

  assign addr = bin[AW-1:0];

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb/tb_fifo_ptr_ctrl.sv - self-checking bench for fifo_ptr_ctrl
module tb_fifo_ptr_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
  endtask

  function automatic int g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return int'(b);
  endfunction

  // Standalone write side (a_*), standalone read side (b_*),
  // cross-connected pair: write side p_*, read side q_*.
  logic       a_rstn = 1'b0, a_inc = 1'b0, a_accept, a_flag, a_almost;
  logic [3:0] a_rg = 4'h0, a_gray, a_level;
  logic [2:0] a_addr;
  logic       b_rstn = 1'b0, b_inc = 1'b0, b_accept, b_flag, b_almost;
  logic [3:0] b_rg = 4'h0, b_gray, b_level;
  logic [2:0] b_addr;
  logic       p_rstn = 1'b0, p_inc = 1'b0, p_accept, p_flag, p_almost;
  logic [3:0] p_gray, p_level;
  logic [2:0] p_addr;
  logic       q_inc = 1'b0, q_accept, q_flag, q_almost;
  logic [3:0] q_gray, q_level;
  logic [2:0] q_addr;

  fifo_ptr_ctrl #(.DEPTH(8), .SYNC_STAGES(2), .MODE(0), .ALMOST_THR(2)) u_wr (
    .clock(clock), .resetn(a_rstn), .inc(a_inc), .remote_gray(a_rg),
    .accept(a_accept), .ptr_gray(a_gray), .addr(a_addr), .flag(a_flag),
    .almost_flag(a_almost), .level(a_level));

  fifo_ptr_ctrl #(.DEPTH(8), .SYNC_STAGES(2), .MODE(1), .ALMOST_THR(2)) u_rd (
    .clock(clock), .resetn(b_rstn), .inc(b_inc), .remote_gray(b_rg),
    .accept(b_accept), .ptr_gray(b_gray), .addr(b_addr), .flag(b_flag),
    .almost_flag(b_almost), .level(b_level));

  fifo_ptr_ctrl #(.DEPTH(8), .SYNC_STAGES(2), .MODE(0), .ALMOST_THR(2)) u_pw (
    .clock(clock), .resetn(p_rstn), .inc(p_inc), .remote_gray(q_gray),
    .accept(p_accept), .ptr_gray(p_gray), .addr(p_addr), .flag(p_flag),
    .almost_flag(p_almost), .level(p_level));

  fifo_ptr_ctrl #(.DEPTH(8), .SYNC_STAGES(2), .MODE(1), .ALMOST_THR(2)) u_pr (
    .clock(clock), .resetn(p_rstn), .inc(q_inc), .remote_gray(p_gray),
    .accept(q_accept), .ptr_gray(q_gray), .addr(q_addr), .flag(q_flag),
    .almost_flag(q_almost), .level(q_level));

  // Pair monitor: Gray pointers move by at most one bit per cycle, and
  // record when the write side wraps its Gray pointer and address.
  logic [3:0] p_gray_prev = 4'h0, q_gray_prev = 4'h0;
  logic [2:0] p_addr_prev = 3'd0;
  int         gray_viol = 0;
  time        gray_wrap_t = 0, addr_wrap_t = 0;

  always @(negedge clock) begin
    if (p_rstn) begin
      if ($countones(p_gray ^ p_gray_prev) > 1) gray_viol <= gray_viol + 1;
      if ($countones(q_gray ^ q_gray_prev) > 1) gray_viol <= gray_viol + 1;
      if (p_gray_prev == 4'h8 && p_gray == 4'h0) gray_wrap_t <= $time;
      if (p_addr_prev == 3'd7 && p_addr == 3'd0) addr_wrap_t <= $time;
      p_gray_prev <= p_gray;
      q_gray_prev <= q_gray;
      p_addr_prev <= p_addr;
    end
  end

  typedef struct {
    logic       inc;
    logic [3:0] rg;
    logic       acc;
    logic [2:0] addr;
    logic [3:0] gray;
    logic       flag;
    logic       almost;
    logic [3:0] level;
  } vec_t;

  vec_t tv1[10];
  vec_t tv2[7];

  function automatic vec_t mk(input logic inc, input logic [3:0] rg, input logic acc,
                              input logic [2:0] addr, input logic [3:0] gray,
                              input logic flag, input logic almost, input logic [3:0] level);
    vec_t v;
    v.inc = inc; v.rg = rg; v.acc = acc; v.addr = addr; v.gray = gray;
    v.flag = flag; v.almost = almost; v.level = level;
    return v;
  endfunction

  // One cycle: drive at the negedge, check accept before the edge and the
  // registered outputs just after it.
  task automatic apply(input vec_t v, input bit rd, input string tag);
    if (rd) begin b_inc = v.inc; b_rg = v.rg; end
    else begin a_inc = v.inc; a_rg = v.rg; end
    #1;
    check({tag, ".accept"}, rd ? b_accept : a_accept, v.acc);
    @(posedge clock); #1;
    check({tag, ".addr"},   rd ? b_addr   : a_addr,   v.addr);
    check({tag, ".gray"},   rd ? b_gray   : a_gray,   v.gray);
    check({tag, ".flag"},   rd ? b_flag   : a_flag,   v.flag);
    check({tag, ".almost"}, rd ? b_almost : a_almost, v.almost);
    check({tag, ".level"},  rd ? b_level  : a_level,  v.level);
    @(negedge clock);
  endtask

  // Reference model for the pair: unbounded accept counts per edge.  Each
  // side sees the peer's count as it stood three edges earlier.
  int wbh[0:1023];
  int rbh[0:1023];
  int pe = 0;

  function automatic int wb_at(input int k);
    return (k < 0) ? 0 : wbh[k];
  endfunction
  function automatic int rb_at(input int k);
    return (k < 0) ? 0 : rbh[k];
  endfunction

  task automatic run_pair(input int n, input int ppush, input int ppop);
    for (int c = 0; c < n; c++) begin
      int wl, rl, occ;
      bit push, pop, aw, ar;
      wl = wb_at(pe) - rb_at(pe - 3);
      rl = wb_at(pe - 3) - rb_at(pe);
      check("pair.wr_level",  p_level,  wl);
      check("pair.wr_full",   p_flag,   int'(wl == 8));
      check("pair.wr_almost", p_almost, int'(wl >= 6));
      check("pair.rd_level",  q_level,  rl);
      check("pair.rd_empty",  q_flag,   int'(rl == 0));
      check("pair.rd_almost", q_almost, int'(rl <= 2));
      push = ($urandom_range(99) < ppush);
      pop  = ($urandom_range(99) < ppop);
      p_inc = push;
      q_inc = pop;
      #1;
      aw = push && (wl != 8);
      ar = pop && (rl != 0);
      check("pair.wr_accept", p_accept, int'(aw));
      check("pair.rd_accept", q_accept, int'(ar));
      occ = (g2b(p_gray) - g2b(q_gray)) & 15;
      check("pair.occupancy_in_range", int'(occ <= 8), 1);
      @(posedge clock);
      pe++;
      wbh[pe] = wb_at(pe - 1) + int'(aw);
      rbh[pe] = rb_at(pe - 1) + int'(ar);
      @(negedge clock);
    end
    p_inc = 1'b0;
    q_inc = 1'b0;
  endtask

  time t4_start;

  initial begin
    // Write side, remote held at 0: eight accepts then full.
    tv1[0] = mk(1'b1, 4'h0, 1'b1, 3'd1, 4'h1, 1'b0, 1'b0, 4'd1);
    tv1[1] = mk(1'b1, 4'h0, 1'b1, 3'd2, 4'h3, 1'b0, 1'b0, 4'd2);
    tv1[2] = mk(1'b1, 4'h0, 1'b1, 3'd3, 4'h2, 1'b0, 1'b0, 4'd3);
    tv1[3] = mk(1'b1, 4'h0, 1'b1, 3'd4, 4'h6, 1'b0, 1'b0, 4'd4);
    tv1[4] = mk(1'b1, 4'h0, 1'b1, 3'd5, 4'h7, 1'b0, 1'b0, 4'd5);
    tv1[5] = mk(1'b1, 4'h0, 1'b1, 3'd6, 4'h5, 1'b0, 1'b1, 4'd6);
    tv1[6] = mk(1'b1, 4'h0, 1'b1, 3'd7, 4'h4, 1'b0, 1'b1, 4'd7);
    tv1[7] = mk(1'b1, 4'h0, 1'b1, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8);
    tv1[8] = mk(1'b1, 4'h0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8);
    tv1[9] = mk(1'b1, 4'h0, 1'b0, 3'd0, 4'hC, 1'b1, 1'b1, 4'd8);
    // Read side: pop while empty dropped, remote bin 2 visible 3 edges on.
    tv2[0] = mk(1'b1, 4'h0, 1'b0, 3'd0, 4'h0, 1'b1, 1'b1, 4'd0);
    tv2[1] = mk(1'b0, 4'h3, 1'b0, 3'd0, 4'h0, 1'b1, 1'b1, 4'd0);
    tv2[2] = mk(1'b0, 4'h3, 1'b0, 3'd0, 4'h0, 1'b1, 1'b1, 4'd0);
    tv2[3] = mk(1'b0, 4'h3, 1'b0, 3'd0, 4'h0, 1'b0, 1'b1, 4'd2);
    tv2[4] = mk(1'b1, 4'h3, 1'b1, 3'd1, 4'h1, 1'b0, 1'b1, 4'd1);
    tv2[5] = mk(1'b1, 4'h3, 1'b1, 3'd2, 4'h3, 1'b1, 1'b1, 4'd0);
    tv2[6] = mk(1'b1, 4'h3, 1'b0, 3'd2, 4'h3, 1'b1, 1'b1, 4'd0);

    repeat (2) @(negedge clock);
    a_rstn = 1'b1; b_rstn = 1'b1; p_rstn = 1'b1;
    #1;
    check("reset.wr_gray",   a_gray,   0);
    check("reset.wr_addr",   a_addr,   0);
    check("reset.wr_flag",   a_flag,   0);
    check("reset.wr_almost", a_almost, 0);
    check("reset.wr_level",  a_level,  0);
    check("reset.rd_flag",   b_flag,   1);
    check("reset.rd_almost", b_almost, 1);
    check("reset.rd_level",  b_level,  0);
    @(negedge clock);

    for (int i = 0; i < 10; i++) apply(tv1[i], 1'b0, $sformatf("t1[%0d]", i));
    a_inc = 1'b0;
    for (int i = 0; i < 7; i++) apply(tv2[i], 1'b1, $sformatf("t2[%0d]", i));
    b_inc = 1'b0;

    // Paired random traffic: fill-biased, drain-biased, balanced.
    run_pair(70, 80, 20);
    run_pair(70, 20, 80);
    run_pair(60, 50, 50);

    // Continuous push/pop across pointer wrap.
    t4_start = $time;
    run_pair(40, 100, 100);
    check("wrap.gray_8_to_0_seen", int'(gray_wrap_t > t4_start), 1);
    check("wrap.addr_7_to_0_seen", int'(addr_wrap_t > t4_start), 1);
    check("gray.one_bit_per_edge_violations", gray_viol, 0);

    // Asynchronous reset in the middle of a cycle.
    a_rstn = 1'b0;
    @(negedge clock);
    a_rstn = 1'b1;
    a_rg = 4'h0;
    a_inc = 1'b1;
    repeat (5) @(negedge clock);
    a_inc = 1'b0;
    #1;
    check("t5.pre_gray",  a_gray,  4'h7);
    check("t5.pre_level", a_level, 5);
    @(posedge clock); #3;
    a_rstn = 1'b0;
    #1;
    check("t5.async_gray",  a_gray,  0);
    check("t5.async_addr",  a_addr,  0);
    check("t5.async_level", a_level, 0);
    check("t5.async_flag",  a_flag,  0);
    @(negedge clock);
    a_rstn = 1'b1;
    a_inc = 1'b1;
    @(posedge clock); #1;
    check("t5.push_after_reset_gray", a_gray, 1);
    @(negedge clock);
    a_inc = 1'b0;

    // Level 7, then a peer pop becomes visible in the same cycle as a push.
    a_rstn = 1'b0;
    @(negedge clock);
    a_rstn = 1'b1;
    a_inc = 1'b1;
    repeat (7) @(negedge clock);
    a_inc = 1'b0;
    #1;
    check("t6.start_level", a_level, 7);
    check("t6.start_flag",  a_flag,  0);
    a_rg = 4'h1;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) a_inc = 1'b1;
      #1;
      if (k == 2) check("t6.accept_with_pop", a_accept, 1);
      @(posedge clock); #1;
      check($sformatf("t6.edge%0d.level", k), a_level, 7);
      check($sformatf("t6.edge%0d.flag", k),  a_flag,  0);
      @(negedge clock);
      a_inc = 1'b0;
    end
    check("t6.gray_after_push", a_gray, 4'hC);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
